// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the streaming program loader.
// Contents: loader state enum, word/byte geometry, header count width.
package boot_loader_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);
  localparam int unsigned CNT_W          = 16;
  localparam int unsigned EXT_ADDR_W     = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_LO,
    ST_HDR_HI,
    ST_PAYLOAD,
    ST_CHECK,
    ST_RUN,
    ST_ERROR
  } state_t;

  // States in which the loader accepts stream bytes.
  function automatic logic is_stream_state(input state_t s);
    return (s == ST_HDR_LO) || (s == ST_HDR_HI) || (s == ST_PAYLOAD) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/byte_word_assembler.sv
// Assembles little-endian 32-bit words from a byte stream (first byte -> bits 7:0).
// Ports:
//   clk, arst_n     : clock, synchronous active-low reset
//   i_clr           : synchronous clear of shift register and byte counter
//   i_valid, i_byte : byte accepted this cycle
//   o_word_valid_c  : high in the cycle the 4th byte of a word is accepted
//   o_word_c        : the completed word (valid with o_word_valid_c)
module byte_word_assembler
  import boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              arst_n,
  input  logic              i_clr,
  input  logic              i_valid,
  input  logic [BYTE_W-1:0] i_byte,
  output logic              o_word_valid_c,
  output logic [WORD_W-1:0] o_word_c
);

  logic [WORD_W-1:0] r_shift;
  logic [BCNT_W-1:0] r_byte_cnt;

  // Right shift so the earliest byte ends up in the least significant lane.
  always_ff @(posedge clk) begin
    if (!arst_n || i_clr) begin
      r_shift    <= '0;
      r_byte_cnt <= '0;
    end else if (i_valid) begin
      r_shift    <= {i_byte, r_shift[WORD_W-1:BYTE_W]};
      r_byte_cnt <= r_byte_cnt + BCNT_W'(1);
    end
  end

  // Word is complete with the incoming byte, so the caller can register it in the same edge.
  assign o_word_valid_c = i_valid && (r_byte_cnt == BCNT_W'(BYTES_PER_WORD - 1));
  assign o_word_c       = {i_byte, r_shift[WORD_W-1:BYTE_W]};

endmodule

// File: rtl/cpu_boot_loader.sv
// Streaming program loader: parses a [CNT_LO, CNT_HI, payload, checksum] byte frame,
// writes assembled words into instruction memory and releases the CPU when the
// XOR checksum matches.
// Ports:
//   clk, arst_n                 : clock, synchronous active-low reset
//   start                       : begin a load from IDLE or ERROR
//   s_valid, s_data, s_ready    : byte stream handshake
//   addr_ext, wen_ext, ren_ext,
//   wdata_ext                   : instruction memory external write port
//   cpu_enable, done, error     : load status / CPU release
module cpu_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 9
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [BYTE_W-1:0]     s_data,
  output logic                  s_ready,
  output logic [EXT_ADDR_W-1:0] addr_ext,
  output logic                  wen_ext,
  output logic                  ren_ext,
  output logic [WORD_W-1:0]     wdata_ext,
  output logic                  cpu_enable,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned MAX_WORDS = 32'(1) << ADDR_W;

  state_t                  r_state;
  logic [BYTE_W-1:0]       r_cnt_lo;
  logic [CNT_W-1:0]        r_n_words;
  logic [CNT_W-1:0]        r_rcv_words;
  logic [ADDR_W-1:0]       r_word_idx;
  logic [BYTE_W-1:0]       r_csum;
  logic                    r_s_ready;
  logic                    r_wen;
  logic [EXT_ADDR_W-1:0]   r_addr;
  logic [WORD_W-1:0]       r_wdata;
  logic                    r_cpu_enable;
  logic                    r_done;
  logic                    r_error;

  logic                    w_xfer;
  logic                    w_start_ok;
  logic                    w_asm_valid;
  logic                    w_word_valid_c;
  logic [WORD_W-1:0]       w_word_c;
  logic [CNT_W-1:0]        w_hdr_n;

  assign w_xfer      = s_valid && r_s_ready;
  assign w_start_ok  = start && ((r_state == ST_IDLE) || (r_state == ST_ERROR));
  assign w_asm_valid = w_xfer && (r_state == ST_PAYLOAD);
  assign w_hdr_n     = {s_data, r_cnt_lo};

  byte_word_assembler u_asm (
    .clk            (clk),
    .arst_n         (arst_n),
    .i_clr          (w_start_ok),
    .i_valid        (w_asm_valid),
    .i_byte         (s_data),
    .o_word_valid_c (w_word_valid_c),
    .o_word_c       (w_word_c)
  );

  // Load sequencer, write register and status outputs.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_state      <= ST_IDLE;
      r_cnt_lo     <= '0;
      r_n_words    <= '0;
      r_rcv_words  <= '0;
      r_word_idx   <= '0;
      r_csum       <= '0;
      r_s_ready    <= 1'b0;
      r_wen        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cpu_enable <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_wen <= 1'b0;
      case (r_state)
        ST_IDLE, ST_ERROR: begin
          if (w_start_ok) begin
            r_state     <= ST_HDR_LO;
            r_s_ready   <= is_stream_state(ST_HDR_LO);
            r_error     <= 1'b0;
            r_word_idx  <= '0;
            r_rcv_words <= '0;
            r_csum      <= '0;
          end
        end
        ST_HDR_LO: begin
          if (w_xfer) begin
            r_cnt_lo <= s_data;
            r_state  <= ST_HDR_HI;
          end
        end
        ST_HDR_HI: begin
          if (w_xfer) begin
            r_n_words <= w_hdr_n;
            if (32'(w_hdr_n) > MAX_WORDS) begin
              r_state   <= ST_ERROR;
              r_s_ready <= 1'b0;
              r_error   <= 1'b1;
            end else if (w_hdr_n == '0) begin
              r_state <= ST_CHECK;
            end else begin
              r_state <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (w_xfer) begin
            r_csum <= r_csum ^ s_data;
            if (w_word_valid_c) begin
              r_wen       <= 1'b1;
              r_addr      <= EXT_ADDR_W'({r_word_idx, 2'b00});
              r_wdata     <= w_word_c;
              r_word_idx  <= r_word_idx + ADDR_W'(1);
              r_rcv_words <= r_rcv_words + CNT_W'(1);
              if (r_rcv_words == (r_n_words - CNT_W'(1))) begin
                r_state <= ST_CHECK;
              end
            end
          end
        end
        ST_CHECK: begin
          // Checksum byte can arrive in the final write cycle; RUN follows that write.
          if (w_xfer) begin
            r_s_ready <= 1'b0;
            if (s_data == r_csum) begin
              r_state      <= ST_RUN;
              r_cpu_enable <= 1'b1;
              r_done       <= 1'b1;
            end else begin
              r_state <= ST_ERROR;
              r_error <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state   <= ST_IDLE;
          r_s_ready <= 1'b0;
        end
      endcase
    end
  end

  assign s_ready    = r_s_ready;
  assign addr_ext   = r_addr;
  assign wen_ext    = r_wen;
  assign ren_ext    = 1'b0;
  assign wdata_ext  = r_wdata;
  assign cpu_enable = r_cpu_enable;
  assign done       = r_done;
  assign error      = r_error;

endmodule
